rr_decoder_arbiter: RTL and testbench



---
 rtl/rr_decoder_arbiter_if.sv | 28 ++
 rtl/rr_decoder_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_decoder_arbiter_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       expired;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  expired
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output expired
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time and a registered one-hot grant.
// Every release passes through one idle cycle, so the decoder select never glitches between owners.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_decoder_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q,     state_d;
    logic [1:0] ptr_q,       ptr_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [3:0] gnt_q,       gnt_d;
    logic [1:0] gnt_idx_q,   gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       expired_q,   expired_d;

    logic [3:0] req_rot;
    logic [3:0] win_onehot;
    logic [1:0] win_off;
    logic [1:0] win_idx;
    logic       any_req;
    logic       own_req;
    logic       others_req;
    logic       hold_last;

    // req_rot[k] is the requester k places after the pointer, so the scan is a plain priority encode.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi]    = bus.req[2'(ptr_q + 2'(gi))];
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 2'(k);
            end
        end
    end

    assign win_idx    = ptr_q + win_off;
    assign any_req    = |bus.req;
    assign own_req    = bus.req[gnt_idx_q];
    assign others_req = |(bus.req & ~gnt_q);
    assign hold_last  = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        expired_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d      = 4'b0000;
                gnt_idx_d  = 2'd0;
                hold_cnt_d = 8'd0;
                if (bus.en && any_req) begin
                    gnt_d     = win_onehot;
                    gnt_idx_d = win_idx;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!bus.en) begin
                    // Enable drop wins over the hold limit and keeps the pointer where it was.
                    state_d    = ST_IDLE;
                    gnt_d      = 4'b0000;
                    gnt_idx_d  = 2'd0;
                    hold_cnt_d = 8'd0;
                end else if (!own_req) begin
                    state_d    = ST_IDLE;
                    gnt_d      = 4'b0000;
                    gnt_idx_d  = 2'd0;
                    hold_cnt_d = 8'd0;
                    ptr_d      = gnt_idx_q + 2'd1;
                end else if (hold_last && others_req) begin
                    state_d    = ST_IDLE;
                    gnt_d      = 4'b0000;
                    gnt_idx_d  = 2'd0;
                    hold_cnt_d = 8'd0;
                    ptr_d      = gnt_idx_q + 2'd1;
                    expired_d  = 1'b1;
                end else if (!hold_last) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 4'b0000;
                gnt_idx_d  = 2'd0;
                hold_cnt_d = 8'd0;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.expired   = expired_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor pops and compares each cycle.
module tb_rr_decoder_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_decoder_arbiter_if bus();

    rr_decoder_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic [3:0] gnt;
        logic       expired;
    } exp_t;

    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input int id, input logic [3:0] eg, input logic ee);
        logic [1:0] ei;
        logic       ev;
        ei = idx_of(eg);
        ev = (eg != 4'b0000);
        checks++;
        if (bus.gnt !== eg || bus.gnt_valid !== ev || bus.expired !== ee ||
            (ev && bus.gnt_idx !== ei)) begin
            failures++;
            $display("FAIL %s #%0d: got gnt=%b idx=%0d valid=%b expired=%b, want gnt=%b idx=%0d valid=%b expired=%b",
                     tag, id, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.expired, eg, ei, ev, ee);
        end else begin
            $display("ok   %s #%0d: req=%b en=%b gnt=%b expired=%b",
                     tag, id, bus.req, bus.en, bus.gnt, bus.expired);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] r, input logic [3:0] eg, input logic ee);
        exp_t x;
        @(negedge clk);
        bus.en  = e;
        bus.req = r;
        step_no++;
        x.id      = step_no;
        x.gnt     = eg;
        x.expired = ee;
        sb_q.push_back(x);
    endtask

    task automatic steps(input int n, input logic e, input logic [3:0] r, input logic [3:0] eg, input logic ee);
        for (int i = 0; i < n; i++) begin
            step(e, r, eg, ee);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
    endtask

    // Monitor: outputs are registered, so compare 1 time unit after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check_outputs("step", x.id, x.gnt, x.expired);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en  = 1'b1;
        bus.req = 4'b0000;
        rst_n   = 1'b0;
        #3;
        check_outputs("reset", 0, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        steps(5, 1'b1, 4'b0000, 4'b0000, 1'b0);

        // Single request, release, then ptr=3 picks requester 3 first.
        step(1'b1, 4'b0100, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 4'b1000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);

        // Full contention: 8 grant cycles per owner then one expired dead cycle; 3 wraps to 0.
        for (int o = 0; o < 5; o++) begin
            steps(8, 1'b1, 4'b1111, 4'(1 << (o % 4)), 1'b0);
            step(1'b1, 4'b1111, 4'b0000, 1'b1);
        end

        // Uncontended owner keeps the grant well past the hold limit.
        steps(50, 1'b1, 4'b0010, 4'b0010, 1'b0);

        // Enable drop, pointer stays at 1.
        steps(3, 1'b0, 4'b0010, 4'b0000, 1'b0);
        step(1'b1, 4'b0011, 4'b0010, 1'b0);
        steps(7, 1'b1, 4'b0011, 4'b0010, 1'b0);
        // Enable falls on the hold-limit cycle: no expired pulse.
        step(1'b0, 4'b0011, 4'b0000, 1'b0);
        step(1'b1, 4'b0011, 4'b0010, 1'b0);

        // Release with a new request in the same cycle: served next, from ptr=2.
        step(1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 4'b0001, 1'b0);
        step(1'b1, 4'b1000, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 4'b1000, 1'b0);
        drain();

        // Asynchronous reset mid-cycle while requester 3 owns the grant.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 0, 4'b0000, 1'b0);
        bus.req = 4'b0000;
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b1001, 4'b0001, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
